// File: rtl/note_freq_synth_ctrl.sv
// Debounced switch-to-frequency mapper with octave shift, saturation and optional glide toward the target.
// Switch edits reach the debounced fields DEBOUNCE_CYCLES+2 cycles after sw settles, then target_freq +1 and freq +2; no backpressure.
module note_freq_synth_ctrl #(
    parameter int FREQ_W          = 12,
    parameter int OCT_W           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLIDE_DIV       = 1000,
    parameter int GLIDE_STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OCT_W+3:0]  sw,
    input  logic              glide_en,
    output logic [FREQ_W-1:0] freq,
    output logic [FREQ_W-1:0] target_freq,
    output logic [2:0]        note,
    output logic [OCT_W-1:0]  octave,
    output logic              accident,
    output logic              changed,
    output logic              gliding
);
    localparam int SW_W   = OCT_W + 4;
    localparam int CALC_W = FREQ_W + OCT_W + 2;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PRE_W  = $clog2(GLIDE_DIV + 1);
    localparam int FW1    = FREQ_W + 1;

    localparam logic [SW_W-1:0]   SW_RST   = SW_W'(5);
    localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(GLIDE_DIV - 1);
    localparam logic [FW1-1:0]    STEP     = FW1'(GLIDE_STEP);
    localparam logic [CALC_W-1:0] SAT      = CALC_W'((1 << FREQ_W) - 1);
    localparam logic [FREQ_W-1:0] F_RST    = FREQ_W'(440);

    logic [SW_W-1:0]   sync1, sync2, cand, deb;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              accept, accept_q;
    logic [PRE_W-1:0]  pre;
    logic              tick;
    logic [3:0]        semi;
    logic [8:0]        base;
    logic [OCT_W:0]    up_sh;
    logic [CALC_W-1:0] wide;
    logic [FREQ_W-1:0] lut;
    logic [FREQ_W-1:0] freq_nxt;
    logic [FW1-1:0]    gap;

    assign note     = deb[2:0];
    assign accident = deb[3];
    assign octave   = deb[SW_W-1:4];
    assign cnt_inc  = cnt + CNT_W'(1);
    assign tick     = (pre == PRE_LAST);

    // The cycle that reloads the candidate already counts as one stable cycle.
    always_comb begin
        accept = 1'b0;
        if (sync2 != deb) begin
            if (sync2 == cand) accept = (cnt_inc == DB_LAST);
            else               accept = (DB_LAST == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= SW_RST;
            deb      <= SW_RST;
            cnt      <= '0;
            accept_q <= 1'b0;
        end else begin
            sync1    <= sw;
            sync2    <= sync1;
            cand     <= sync2;
            accept_q <= accept;
            if (accept || (sync2 != cand) || (sync2 == deb)) cnt <= '0;
            else                                            cnt <= cnt_inc;
            if (accept) deb <= sync2;
        end
    end

    always_comb begin
        semi  = 4'd0;
        base  = 9'd0;
        up_sh = '0;
        wide  = '0;
        lut   = '0;
        case (note)
            3'd0:    semi = 4'd0;
            3'd1:    semi = 4'd2;
            3'd2:    semi = 4'd4;
            3'd3:    semi = 4'd5;
            3'd4:    semi = 4'd7;
            3'd5:    semi = 4'd9;
            3'd6:    semi = 4'd11;
            default: semi = 4'd0;
        endcase
        if (accident && (note != 3'd2) && (note != 3'd6)) semi = semi + 4'd1;
        case (semi)
            4'd0:    base = 9'd261;
            4'd1:    base = 9'd277;
            4'd2:    base = 9'd293;
            4'd3:    base = 9'd311;
            4'd4:    base = 9'd330;
            4'd5:    base = 9'd349;
            4'd6:    base = 9'd370;
            4'd7:    base = 9'd392;
            4'd8:    base = 9'd415;
            4'd9:    base = 9'd440;
            4'd10:   base = 9'd466;
            default: base = 9'd494;
        endcase
        // All-ones octave code is octave 3; note 7's extra octave cancels the right shift.
        up_sh = {1'b0, octave} + {{OCT_W{1'b0}}, (note == 3'd7)};
        if (&octave) wide = (note == 3'd7) ? CALC_W'(base) : CALC_W'(base >> 1);
        else         wide = CALC_W'(base) << up_sh;
        lut = (wide > SAT) ? '1 : wide[FREQ_W-1:0];
    end

    always_comb begin
        freq_nxt = freq;
        gap      = '0;
        if (!glide_en) begin
            freq_nxt = target_freq;
        end else if (tick) begin
            if (target_freq > freq) begin
                gap      = {1'b0, target_freq} - {1'b0, freq};
                freq_nxt = (gap <= STEP) ? target_freq : freq + FREQ_W'(GLIDE_STEP);
            end else begin
                gap      = {1'b0, freq} - {1'b0, target_freq};
                freq_nxt = (gap <= STEP) ? target_freq : freq - FREQ_W'(GLIDE_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre         <= '0;
            target_freq <= F_RST;
            freq        <= F_RST;
            changed     <= 1'b0;
            gliding     <= 1'b0;
        end else begin
            pre         <= tick ? '0 : pre + PRE_W'(1);
            target_freq <= lut;
            changed     <= accept_q;
            freq        <= freq_nxt;
            gliding     <= (freq_nxt != lut);
        end
    end
endmodule

// File: tb/tb_note_freq_synth_ctrl.sv
// Scoreboard bench: expected target frequencies are queued as switches are driven and popped on each changed pulse.
module tb_note_freq_synth_ctrl;
    localparam int FW = 12;
    localparam int GD = 2;
    localparam int GS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        glide_en = 1'b0;
    logic [5:0]  sw = 6'b000101;

    logic [11:0] freq_a, target_a;
    logic [2:0]  note_a;
    logic [1:0]  octave_a;
    logic        accident_a, changed_a, gliding_a;
    logic [9:0]  freq_b, target_b;
    logic [2:0]  note_b;
    logic [1:0]  octave_b;
    logic        accident_b, changed_b, gliding_b;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int base_tbl[12] = '{261, 277, 293, 311, 330, 349, 370, 392, 415, 440, 466, 494};
    int semi_of[8]   = '{0, 2, 4, 5, 7, 9, 11, 0};

    always #5 clk = ~clk;

    note_freq_synth_ctrl #(.FREQ_W(12), .OCT_W(2), .DEBOUNCE_CYCLES(4), .GLIDE_DIV(GD), .GLIDE_STEP(GS)) dut_a (
        .clk(clk), .rst(rst), .sw(sw), .glide_en(glide_en), .freq(freq_a), .target_freq(target_a),
        .note(note_a), .octave(octave_a), .accident(accident_a), .changed(changed_a), .gliding(gliding_a));

    note_freq_synth_ctrl #(.FREQ_W(10), .OCT_W(2), .DEBOUNCE_CYCLES(4), .GLIDE_DIV(GD), .GLIDE_STEP(GS)) dut_b (
        .clk(clk), .rst(rst), .sw(sw), .glide_en(glide_en), .freq(freq_b), .target_freq(target_b),
        .note(note_b), .octave(octave_b), .accident(accident_b), .changed(changed_b), .gliding(gliding_b));

    function automatic int model(input int code, input int fw);
        int n, acc, oc, s, v;
        n = code & 7;
        acc = (code >> 3) & 1;
        oc = (code >> 4) & 3;
        s = semi_of[n];
        if (acc == 1 && n != 2 && n != 6) s++;
        v = base_tbl[s];
        if (oc == 3) begin
            if (n != 7) v = v / 2;
        end else begin
            v = v << (oc + ((n == 7) ? 1 : 0));
        end
        if (v > (1 << fw) - 1) v = (1 << fw) - 1;
        return v;
    endfunction

    function automatic int gstep(input int f, input int t);
        if (t > f) return (t - f <= GS) ? t : f + GS;
        return (f - t <= GS) ? t : f - GS;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_changed(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (changed_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; glide_en = 1'b0; sw = 6'b000101;
        repeat (3) step();
        vectors++; if (freq_a !== 12'd440) begin miscompares++; $display("FAIL reset_freq got %0d want 440", freq_a); end
        vectors++; if (target_a !== 12'd440) begin miscompares++; $display("FAIL reset_target got %0d want 440", target_a); end
        vectors++; if ({octave_a, accident_a, note_a} !== 6'b000101) begin miscompares++;
            $display("FAIL reset_fields got %b want 000101", {octave_a, accident_a, note_a}); end
        vectors++; if ({changed_a, gliding_a} !== 2'b00) begin miscompares++;
            $display("FAIL reset_flags got %b want 00", {changed_a, gliding_a}); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (changed_a !== 1'b0 || freq_a !== 12'd440) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL reset_hold got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_latency();
        int bad, e;
        sw = 6'b000000;
        exp_q.push_back(model(0, FW));
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i <= 5 && (note_a !== 3'd5 || changed_a !== 1'b0)) bad++;
            if (i == 6) begin
                vectors++; if (note_a !== 3'd0 || changed_a !== 1'b0) begin miscompares++;
                    $display("FAIL lat_deb note %0d changed %0d want 0/0", note_a, changed_a); end
            end
            if (i == 7) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                vectors++; if (changed_a !== 1'b1 || target_a !== e[11:0] || freq_a !== 12'd440) begin miscompares++;
                    $display("FAIL lat_target chg %0d tgt %0d freq %0d want 1/%0d/440", changed_a, target_a, freq_a, e); end
            end
            if (i == 8) begin
                vectors++; if (freq_a !== 12'd261 || changed_a !== 1'b0 || gliding_a !== 1'b0) begin miscompares++;
                    $display("FAIL lat_freq freq %0d chg %0d gl %0d want 261/0/0", freq_a, changed_a, gliding_a); end
            end
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL lat_early got %0d early updates want 0", bad); end
    endtask

    task automatic test_sweep();
        bit ok;
        int e;
        logic [5:0] c;
        for (int code = 1; code < 64; code++) begin
            c = code[5:0];
            sw = c;
            exp_q.push_back(model(code, FW));
            wait_changed(20, ok);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            vectors++;
            if (!ok || target_a !== e[11:0]) begin miscompares++;
                $display("FAIL sweep_target sw %b got %0d want %0d (pulse %0d)", c, target_a, e, ok); end
            vectors++;
            if ({octave_a, accident_a, note_a} !== c) begin miscompares++;
                $display("FAIL sweep_fields got %b want %b", {octave_a, accident_a, note_a}, c); end
            step();
            vectors++;
            if (freq_a !== e[11:0]) begin miscompares++; $display("FAIL sweep_freq sw %b got %0d want %0d", c, freq_a, e); end
        end
    endtask

    task automatic test_bounce();
        bit ok;
        int e, pulses, bad;
        sw = 6'b000000;
        exp_q.push_back(model(0, FW));
        wait_changed(20, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        vectors++; if (!ok || target_a !== e[11:0]) begin miscompares++;
            $display("FAIL bounce_setup got %0d want %0d", target_a, e); end
        pulses = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            sw = (((i / 2) % 2) == 0) ? 6'b000001 : 6'b000000;
            step();
            if (changed_a) pulses++;
            if (target_a !== 12'd261) bad++;
        end
        sw = 6'b000001;
        exp_q.push_back(model(1, FW));
        for (int i = 0; i < 20; i++) begin
            step();
            if (target_a !== 12'd261 && target_a !== 12'd293) bad++;
            if (changed_a) begin
                pulses++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                vectors++; if (target_a !== e[11:0]) begin miscompares++;
                    $display("FAIL bounce_target got %0d want %0d", target_a, e); end
            end
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL bounce_glitch got %0d stray targets want 0", bad); end
    endtask

    task automatic test_glide();
        bit ok, done;
        int e, prev, cyc, last, bad;
        glide_en = 1'b0; sw = 6'b000101;
        exp_q.push_back(model(5, FW));
        wait_changed(20, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        step();
        vectors++; if (!ok || freq_a !== e[11:0]) begin miscompares++; $display("FAIL glide_setup got %0d want %0d", freq_a, e); end
        glide_en = 1'b1; sw = 6'b000110;
        exp_q.push_back(model(6, FW));
        wait_changed(20, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        vectors++; if (!ok || target_a !== e[11:0]) begin miscompares++; $display("FAIL glide_target got %0d want %0d", target_a, e); end
        prev = freq_a; cyc = 0; last = -1; done = 1'b0; bad = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            cyc++;
            if (freq_a !== prev[11:0]) begin
                vectors++; if (freq_a !== gstep(prev, 494)) begin miscompares++;
                    $display("FAIL glide_step got %0d want %0d", freq_a, gstep(prev, 494)); end
                if (last >= 0 && cyc - last != GD) bad++;
                last = cyc;
                prev = freq_a;
                if (freq_a == 12'd494) begin
                    done = 1'b1;
                    vectors++; if (gliding_a !== 1'b0) begin miscompares++; $display("FAIL glide_done gliding %0d want 0", gliding_a); end
                end
            end else if (gliding_a !== 1'b1) bad++;
        end
        vectors++; if (!done || bad != 0) begin miscompares++;
            $display("FAIL glide_timing reached %0d irregular %0d want 1/0", done, bad); end
    endtask

    task automatic test_retarget();
        bit ok, done;
        int e, pf, pt, downs;
        glide_en = 1'b0; sw = 6'b000101;
        exp_q.push_back(model(5, FW));
        wait_changed(20, ok);
        void'(exp_q.pop_front());
        step();
        glide_en = 1'b1; sw = 6'b000110;
        exp_q.push_back(model(6, FW));
        wait_changed(20, ok);
        void'(exp_q.pop_front());
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (freq_a == 12'd470) ok = 1'b1;
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL retarget_470 got %0d want 470", freq_a); end
        sw = 6'b000000;
        exp_q.push_back(model(0, FW));
        pf = freq_a; pt = target_a; downs = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (changed_a) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                vectors++; if (target_a !== e[11:0]) begin miscompares++; $display("FAIL retarget_tgt got %0d want %0d", target_a, e); end
            end
            if (freq_a !== pf[11:0]) begin
                vectors++; if (freq_a !== gstep(pf, pt)) begin miscompares++;
                    $display("FAIL retarget_step got %0d want %0d", freq_a, gstep(pf, pt)); end
                if (freq_a < pf) downs++;
            end
            pf = freq_a; pt = target_a;
            if (downs == 2) begin
                glide_en = 1'b0;
                step();
                done = 1'b1;
                vectors++; if (freq_a !== 12'd261 || gliding_a !== 1'b0) begin miscompares++;
                    $display("FAIL glide_off freq %0d gliding %0d want 261/0", freq_a, gliding_a); end
            end
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL retarget_descent got %0d steps want 2", downs); end
    endtask

    task automatic test_reset_mid_glide();
        bit ok;
        int e;
        glide_en = 1'b1; sw = 6'b000110;
        exp_q.push_back(model(6, FW));
        wait_changed(20, ok);
        void'(exp_q.pop_front());
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (freq_a != 12'd261 && gliding_a) ok = 1'b1;
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstglide_start freq %0d want moving", freq_a); end
        rst = 1'b1;
        step();
        vectors++; if (freq_a !== 12'd440 || gliding_a !== 1'b0 || target_a !== 12'd440 || note_a !== 3'd5) begin miscompares++;
            $display("FAIL rstglide freq %0d gl %0d tgt %0d note %0d want 440/0/440/5", freq_a, gliding_a, target_a, note_a); end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(model(6, FW));
        wait_changed(20, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        vectors++; if (!ok || target_a !== e[11:0]) begin miscompares++; $display("FAIL rstglide_after got %0d want %0d", target_a, e); end
    endtask

    task automatic test_saturation();
        bit ok;
        int e;
        glide_en = 1'b0; sw = 6'b100101;
        exp_q.push_back(model(37, FW));
        wait_changed(20, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        vectors++; if (!ok || target_a !== e[11:0]) begin miscompares++; $display("FAIL sat_wide got %0d want %0d", target_a, e); end
        vectors++; if (changed_b !== 1'b1 || target_b !== 10'(model(37, 10))) begin miscompares++;
            $display("FAIL sat_narrow got %0d want %0d", target_b, model(37, 10)); end
        step();
        vectors++; if (freq_b !== 10'd1023) begin miscompares++; $display("FAIL sat_freq got %0d want 1023", freq_b); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_bounce();
        test_glide();
        test_retarget();
        test_reset_mid_glide();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
